// File: rtl/hash_round_ctrl.sv
// hash_round_ctrl: round sequencer for the hash datapath.
// Accepts a message, drives the external 3-bit round counter (init/en/co),
// strobes load/step/finalize, then holds the result until it is taken.
// Optional build macro HASH_ROUND_CTRL_SHADOW_EN adds an internal shadow
// counter that cross-checks rnd_co and raises a sticky err on disagreement.
module hash_round_ctrl #(
    parameter int ROUNDS = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    output logic in_ready,
    input  logic abort,
    output logic ld_msg,
    output logic rnd_init,
    output logic rnd_en,
    input  logic rnd_co,
    output logic rnd_step,
    output logic fin,
    output logic out_valid,
    input  logic out_ready,
    output logic busy,
    output logic err
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] INIT  = 3'd1;
    localparam logic [2:0] RUN   = 3'd2;
    localparam logic [2:0] FINAL = 3'd3;
    localparam logic [2:0] HOLD  = 3'd4;

    localparam logic [2:0] ROUNDS_CNT = 3'(ROUNDS);

    logic [2:0] state;
    logic [2:0] state_next;
    logic       shadow_err;

`ifdef HASH_ROUND_CTRL_SHADOW_EN
    logic [2:0] shadow;
    logic       err_q;

    // Shadow of the external round counter: cleared in INIT, follows rnd_en.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow <= 3'd0;
        end else if (state == INIT) begin
            shadow <= 3'd0;
        end else if (rnd_en) begin
            shadow <= shadow + 3'd1;
        end
    end

    // Carry-out and shadow count must agree while rounds are running.
    always_comb begin
        shadow_err = 1'b0;
        if (state == RUN) begin
            shadow_err = (rnd_co && (shadow != ROUNDS_CNT)) ||
                         (!rnd_co && (shadow == ROUNDS_CNT));
        end
    end

    // Sticky error flag; an abort in the same cycle takes precedence.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (shadow_err && !abort) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign shadow_err = 1'b0;
    assign err        = 1'b0;
`endif

    // State register; reset discards any job in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; abort beats both rnd_co and out_ready.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (in_valid && !abort) begin
                    state_next = INIT;
                end
            end
            INIT: begin
                state_next = abort ? IDLE : RUN;
            end
            RUN: begin
                if (abort || shadow_err) begin
                    state_next = IDLE;
                end else if (rnd_co) begin
                    state_next = FINAL;
                end
            end
            FINAL: begin
                state_next = abort ? IDLE : HOLD;
            end
            HOLD: begin
                if (abort || out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output decode; strobes are mutually exclusive, an abort or shadow
    // mismatch replaces the normal strobe with a counter clear.
    always_comb begin
        in_ready  = (state == IDLE);
        busy      = (state != IDLE);
        out_valid = (state == HOLD);
        ld_msg    = (state == IDLE) && in_valid && !abort;
        rnd_init  = (state == INIT) ||
                    ((state != IDLE) && abort) ||
                    shadow_err;
        rnd_step  = (state == RUN) && !rnd_co && !abort && !shadow_err;
        rnd_en    = rnd_step;
        fin       = (state == FINAL) && !abort;
    end

endmodule

// File: doc/hash_round_ctrl.md
Name: hash_round_ctrl

Overview:
- Round sequencer on the control side of the hash datapath's 3-bit round counter; this block drives the counter's `init`/`en` and consumes its `co`.
- Accepts a message from the host with a valid/ready handshake and pulses datapath load, round-step and finalize strobes.
- Presents the result with a valid/ready handshake, then returns to idle.

Parameters:
- ROUNDS, 5, number of round-step pulses per message; must equal the counter's CARRYOUT; legal range 1..7.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  host offers a message.
- in_ready  output  1  controller can accept a message.
- abort  input  1  synchronous abort of the current job.
- ld_msg  output  1  datapath captures the input message this cycle.
- rnd_init  output  1  to round counter `init`; clears the count.
- rnd_en  output  1  to round counter `en`; increments the count.
- rnd_co  input  1  round counter carry-out (count == ROUNDS).
- rnd_step  output  1  datapath executes one round this cycle.
- fin  output  1  datapath final mixing / output register load.
- out_valid  output  1  hash result valid.
- out_ready  input  1  consumer takes the result.
- busy  output  1  high in every state except IDLE.
- err  output  1  sticky round-count error (optional feature only).

Behaviour:
- One clock domain; all state updates on rising `clk`. `rst` is synchronous active-high.
- Reset behaviour:
  - state <= IDLE; err <= 0.
  - After reset, in_ready=1 and every other output is 0.
  - `rst` mid-job discards the job; the counter is cleared by the shared `rst`.
- States: IDLE, INIT, RUN, FINAL, HOLD. All outputs are decoded from state; `ld_msg` and `rnd_en` also qualify on inputs.
- IDLE:
  - in_ready=1; ld_msg = in_valid & ~abort.
  - If in_valid & ~abort: go to INIT.
- INIT:
  - rnd_init=1 for exactly one cycle; go to RUN.
- RUN:
  - rnd_step = ~rnd_co; rnd_en = ~rnd_co.
  - When rnd_co=1: no step and no increment; go to FINAL.
  - Net result: exactly ROUNDS step pulses on consecutive cycles, then one co cycle.
- FINAL:
  - fin=1 for one cycle; go to HOLD.
- HOLD:
  - out_valid=1, held until out_ready=1, then go to IDLE.
  - out_valid must not drop before out_ready.
  - in_ready=0 in HOLD, so a new message is never accepted in the same cycle as the result is taken.
- Latency, with the handshake in cycle 0:
  - INIT = cycle 1.
  - RUN = cycles 2..ROUNDS+2; steps in cycles 2..ROUNDS+1.
  - FINAL = cycle ROUNDS+3.
  - out_valid first high in cycle ROUNDS+4 (9 for ROUNDS=5).
  - Back-to-back throughput is one message per ROUNDS+5 cycles with out_ready tied high.
- Abort:
  - In INIT, RUN, FINAL or HOLD: next state IDLE and rnd_init=1 in the abort cycle; no fin and no out_valid after that.
  - In IDLE: abort blocks acceptance that cycle.
  - Abort has priority over rnd_co and out_ready.
- rnd_co is ignored outside RUN.
- At most one of ld_msg, rnd_init, rnd_step, fin is high in any cycle.

Optional Feature:
- Macro: HASH_ROUND_CTRL_SHADOW_EN.
- Defined:
  - Internal 3-bit shadow counter: cleared in INIT, incremented with rnd_en.
  - If rnd_co=1 while shadow != ROUNDS, or shadow == ROUNDS while rnd_co=0 in RUN: err <= 1 (sticky until rst), next state IDLE, rnd_init pulsed, no fin.
- Undefined:
  - No shadow logic; err tied 0; rnd_co is trusted.

Test Plan:
- Reset check: rst high 2 cycles, then low -> in_ready=1, busy=0, out_valid=0, err=0, all strobes 0.
- Single job, ROUNDS=5, out_ready=1, counter model attached:
  - in_valid pulsed at cycle 0 -> ld_msg at 0, rnd_init at 1, rnd_step at 2..6, co at 7, fin at 8, out_valid at 9.
  - Idle again at 10; exactly 5 rnd_en pulses.
- Output backpressure: out_ready held 0 for 6 cycles after out_valid -> out_valid stays 1 and in_ready stays 0; in_valid asserted meanwhile is not accepted; out_ready=1 -> IDLE next cycle.
- Abort in RUN after 2 steps -> rnd_init in the abort cycle, IDLE next, no fin, no out_valid. Abort and in_valid together in IDLE -> no ld_msg.
- Synchronous reset in FINAL -> IDLE at the next edge, fin does not repeat, out_valid never rises.
- With HASH_ROUND_CTRL_SHADOW_EN: counter model forced to assert co after 3 steps -> err=1 sticky, no fin, IDLE. Without the macro, the same stimulus -> fin and out_valid as normal, err=0.
